memory_sequencer: RTL and testbench
===================================

// Module: memory_sequencer
//
// PURPOSE
//   Upstream access sequencer for the 8x8 memory_unit array.
//   - Write side: accepts a byte stream over a valid/ready handshake and writes
//     it to consecutive addresses from 0. It drives addr, data-in and rw of
//     memory_unit.
//   - Read side: on command, replays the stored bytes in address order over a
//     valid/ready output stream.
//   - Replaces hand-timed stimulus (stepping addr each period) with a clocked
//     handshake.
//
// PARAMETERS
//   DEPTH  8  number of memory words; must equal 2**AW
//   AW     3  address width
//   DW     8  data width
//
// PORTS
//   clk       in   1     system clock, rising edge
//   rst_n     in   1     asynchronous active-low reset
//   s_data    in   DW    write byte
//   s_valid   in   1     write byte valid
//   s_ready   out  1     write byte accepted when s_valid & s_ready
//   rd_start  in   1     one-cycle pulse: start readback (sampled in IDLE only)
//   clr       in   1     one-cycle pulse: count := 0 (sampled in IDLE only)
//   m_data    out  DW    readback byte
//   m_valid   out  1     readback byte valid
//   m_ready   in   1     downstream accepts when m_valid & m_ready
//   rd_done   out  1     one-cycle pulse after the last readback byte is accepted
//   busy      out  1     high in any state other than IDLE
//   count     out  AW+1  number of bytes stored, 0..DEPTH
//   mem_addr  out  AW    to memory_unit addr
//   mem_din   out  DW    to memory_unit data inputs
//   mem_rw    out  1     to memory_unit rw; 1 = write cycle, 0 = read
//   mem_dout  in   DW    from memory_unit outputs; combinational from mem_addr
//
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, count=0, rd pointer=0,
//     mem_addr=0, mem_din=0, mem_rw=0, m_valid=0, m_data=0, rd_done=0.
//     Memory contents are not cleared.
//   Registered outputs: all except s_ready.
//     s_ready = (state==IDLE) & (count<DEPTH) & ~rd_start.
//   States:
//   IDLE
//     - rd_start=1 (priority 1):
//       - count==0: rd_done=1 next cycle, stay IDLE, no m_valid.
//       - else: ptr=0, mem_addr=0, go RD_ADDR.
//     - clr=1 (priority 2): count=0.
//     - s_valid & s_ready (priority 3): mem_addr=count[AW-1:0], mem_din=s_data,
//       mem_rw=1, go WR.
//     - Priority is rd_start > clr > write. A write coinciding with rd_start is
//       not accepted (s_ready low).
//   WR (exactly 1 cycle)
//     - mem_rw=1 held for this single cycle.
//     - Exit: mem_rw=0, count=count+1, go IDLE.
//     - Write throughput: 1 byte per 2 cycles.
//   RD_ADDR (1 cycle, address settle)
//     - mem_rw=0, mem_addr=ptr.
//     - Exit: go RD_CAP.
//   RD_CAP (1 cycle)
//     - m_data=mem_dout, m_valid=1.
//     - Exit: go RD_HOLD.
//   RD_HOLD
//     - m_data and m_valid held stable until m_ready.
//     - On accept, m_valid=0, then:
//       - if ptr==count-1: rd_done=1, go IDLE.
//       - else: ptr+1, mem_addr=ptr+1, go RD_ADDR.
//     - Read latency: 2 cycles from address to m_valid. Best throughput is
//       1 byte per 3 cycles.
//   Boundary conditions:
//   - Full (count==DEPTH): s_ready=0. Bytes stall and are never dropped or
//     overwritten.
//   - count never wraps. mem_addr uses count[AW-1:0] only while count<DEPTH.
//   - rd_start/clr outside IDLE: ignored.
//   - s_valid outside IDLE: not accepted.
//   - Readback is non-destructive: count is unchanged, and repeat rd_start
//     replays the same data.
//   - Reset mid-WR or mid-read: immediate IDLE, mem_rw drops to 0 asynchronously,
//     and no rd_done is generated.
//   - rd_done and m_valid are never high in the same cycle.
//
// TESTING
//   1. Write "Karl!!!!" (8 bytes, s_valid held) then pulse rd_start with
//      m_ready=1.
//      -> count=8; m_data sequence 0x4B,0x61,0x72,0x6C,0x21,0x21,0x21,0x21;
//         rd_done once; mem_rw high exactly 8 cycles.
//   2. Offer a 9th byte when count=8.
//      -> s_ready=0 indefinitely; count stays 8; no mem_rw pulse.
//   3. Readback with m_ready low 5 cycles per byte.
//      -> m_valid/m_data stable throughout the stall; no byte skipped or
//         repeated.
//   4. rd_start with count=0.
//      -> rd_done=1 next cycle, m_valid never asserted, busy stays 0.
//   5. rd_start, clr and s_valid asserted together in IDLE with count=3.
//      -> readback of 3 bytes starts; write not accepted; count still 3;
//         then clr alone -> count=0.
//   6. Assert rst_n=0 while in RD_HOLD after 2 bytes.
//      -> all outputs reset values within the same cycle; a later rd_start with
//         count=0 yields only rd_done.

Source files
------------

// File: rtl/memory_sequencer.sv
// Handshake-driven access sequencer for an 8x8 memory_unit array.
// Writes an incoming byte stream to consecutive addresses and replays it on command.
module memory_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          rd_start,
  input  logic          clr,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          rd_done,
  output logic          busy,
  output logic [AW:0]   count,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_dout
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, RD_HOLD} state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic          full;
  logic          last;

  assign full    = (count == DEPTH_C);
  // Only ever evaluated during readback, where count >= 1.
  assign last    = ({1'b0, ptr} == (count - CW'(1)));
  assign s_ready = (state == IDLE) && !full && !rd_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      ptr      <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_rw   <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      rd_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        // rd_start beats clr, clr beats an offered write byte
        IDLE: begin
          if (rd_start) begin
            if (count == '0) begin
              rd_done <= 1'b1;
            end else begin
              ptr      <= '0;
              mem_addr <= '0;
              busy     <= 1'b1;
              state    <= RD_ADDR;
            end
          end else if (clr) begin
            count <= '0;
          end else if (s_valid && s_ready) begin
            mem_addr <= count[AW-1:0];
            mem_din  <= s_data;
            mem_rw   <= 1'b1;
            busy     <= 1'b1;
            state    <= WR;
          end
        end
        WR: begin
          mem_rw <= 1'b0;
          count  <= count + CW'(1);
          busy   <= 1'b0;
          state  <= IDLE;
        end
        RD_ADDR: begin
          mem_rw   <= 1'b0;
          mem_addr <= ptr;
          state    <= RD_CAP;
        end
        RD_CAP: begin
          m_data  <= mem_dout;
          m_valid <= 1'b1;
          state   <= RD_HOLD;
        end
        RD_HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (last) begin
              rd_done <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              ptr      <= ptr + AW'(1);
              mem_addr <= ptr + AW'(1);
              state    <= RD_ADDR;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sequencer.sv
// Bench for memory_sequencer: memory_unit model, stored-byte/expected-stream model,
// per-cycle stream checks plus directed scenarios with literal expectations.
module tb_memory_sequencer;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          rd_start = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          rd_done;
  logic          busy;
  logic [AW:0]   count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_rw;
  logic [DW-1:0] mem_dout;

  memory_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .rd_start(rd_start), .clr(clr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .rd_done(rd_done), .busy(busy), .count(count), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_rw(mem_rw), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // memory_unit: synchronous write, combinational read
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
  always @(posedge clk) if (mem_rw) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes stored so far, expected readback stream, accepted bytes
  logic [DW-1:0] stored [DEPTH];
  int            model_cnt = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int            rd_done_cnt = 0;
  int            wr_cycles = 0;
  int            mvalid_cycles = 0;
  int            busy_cycles = 0;
  int            stall = 0;

  logic          prev_valid = 1'b0;
  logic          prev_acc = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
    end else begin
      if (mem_rw) wr_cycles++;
      if (busy) busy_cycles++;
      if (model_cnt >= int'(DEPTH)) check("full_s_ready", 32'(s_ready), 0);
      if (rd_start) check("s_ready_rd_start", 32'(s_ready), 0);
      if (s_valid && s_ready) begin
        stored[model_cnt[AW-1:0]] = s_data;
        model_cnt++;
      end
      if (m_valid) begin
        mvalid_cycles++;
        if (prev_valid && !prev_acc) begin
          check("m_data_stable", 32'(m_data), 32'(prev_data));
        end else if (exp_q.size() == 0) begin
          check("m_valid_unexpected", 32'(m_valid), 0);
        end else begin
          check("m_data", 32'(m_data), 32'(exp_q[0]));
        end
        prev_acc = m_ready;
        if (m_ready) begin
          got_q.push_back(m_data);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end else begin
        prev_acc = 1'b0;
      end
      prev_valid = m_valid;
      prev_data  = m_data;
      if (rd_done) begin
        rd_done_cnt++;
        check("rd_done_excl_m_valid", 32'(m_valid), 0);
        check("rd_done_all_accepted", 32'(exp_q.size()), 0);
      end
    end
  end

  // Downstream: accept after `stall` cycles of m_valid
  int wait_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      if (wait_cnt >= stall) begin m_ready = 1'b1; wait_cnt = 0; end
      else begin m_ready = 1'b0; wait_cnt++; end
    end else begin
      m_ready  = (stall == 0);
      wait_cnt = 0;
    end
  end

  task automatic write_byte(input logic [DW-1:0] b);
    int n = 0;
    s_data = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_ready) check("write_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic start_read(input logic with_clr, input logic with_valid);
    rd_start = 1'b1;
    clr = with_clr;
    s_valid = with_valid;
    for (int i = 0; i < model_cnt; i++) exp_q.push_back(stored[i]);
    @(posedge clk); #1;
    rd_start = 1'b0;
    clr = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    model_cnt = 0;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  logic [DW-1:0] karl [8];
  int w0, d0, v0, b0, n;

  initial begin
    karl = '{8'h4B, 8'h61, 8'h72, 8'h6C, 8'h21, 8'h21, 8'h21, 8'h21};
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_mem_rw", 32'(mem_rw), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: write "Karl!!!!" then read back at full speed
    stall = 0;
    w0 = wr_cycles;
    for (int i = 0; i < 8; i++) write_byte(karl[i]);
    wait_idle();
    check("t1_count", 32'(count), 8);
    check("t1_wr_cycles", 32'(wr_cycles - w0), 8);
    got_q.delete();
    d0 = rd_done_cnt;
    start_read(1'b0, 1'b0);
    wait_idle();
    @(posedge clk); #1;
    check("t1_got_len", 32'(got_q.size()), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("t1_byte", 32'(got_q[i]), 32'(karl[i]));
    check("t1_rd_done_once", 32'(rd_done_cnt - d0), 1);
    check("t1_count_after", 32'(count), 8);

    // 2: ninth byte while full
    w0 = wr_cycles;
    s_data = 8'h55;
    s_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t2_s_ready", 32'(s_ready), 0);
    s_valid = 1'b0;
    check("t2_count", 32'(count), 8);
    check("t2_no_write", 32'(wr_cycles - w0), 0);

    // 3: readback with downstream stalls
    stall = 5;
    got_q.delete();
    d0 = rd_done_cnt;
    start_read(1'b0, 1'b0);
    wait_idle();
    @(posedge clk); #1;
    check("t3_got_len", 32'(got_q.size()), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("t3_byte", 32'(got_q[i]), 32'(karl[i]));
    check("t3_rd_done_once", 32'(rd_done_cnt - d0), 1);
    stall = 0;

    // 4: readback of an empty store
    pulse_clr();
    check("t4_count_clr", 32'(count), 0);
    v0 = mvalid_cycles;
    b0 = busy_cycles;
    start_read(1'b0, 1'b0);
    check("t4_rd_done", 32'(rd_done), 1);
    check("t4_busy", 32'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_m_valid", 32'(mvalid_cycles - v0), 0);
    check("t4_busy_never", 32'(busy_cycles - b0), 0);

    // 5: rd_start + clr + s_valid together with count=3
    write_byte(8'hA1);
    write_byte(8'hB2);
    write_byte(8'hC3);
    wait_idle();
    check("t5_count3", 32'(count), 3);
    got_q.delete();
    w0 = wr_cycles;
    s_data = 8'hEE;
    start_read(1'b1, 1'b1);
    wait_idle();
    @(posedge clk); #1;
    check("t5_got_len", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      check("t5_b0", 32'(got_q[0]), 32'hA1);
      check("t5_b2", 32'(got_q[2]), 32'hC3);
    end
    check("t5_no_write", 32'(wr_cycles - w0), 0);
    check("t5_count_kept", 32'(count), 3);
    pulse_clr();
    check("t5_count_clr", 32'(count), 0);

    // 6: reset in RD_HOLD after two accepted bytes
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    wait_idle();
    stall = 5;
    got_q.delete();
    start_read(1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(got_q.size() == 2 && m_valid) && n < 200) begin @(negedge clk); n++; end
    check("t6_reached_hold", 32'(got_q.size() == 2 && m_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_m_valid", 32'(m_valid), 0);
    check("t6_m_data", 32'(m_data), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_count", 32'(count), 0);
    check("t6_mem_rw", 32'(mem_rw), 0);
    check("t6_mem_addr", 32'(mem_addr), 0);
    check("t6_rd_done", 32'(rd_done), 0);
    check("t6_s_ready", 32'(s_ready), 1);
    exp_q.delete();
    model_cnt = 0;
    stall = 0;
    d0 = rd_done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_rd_done", 32'(rd_done_cnt - d0), 0);
    v0 = mvalid_cycles;
    start_read(1'b0, 1'b0);
    check("t6_empty_rd_done", 32'(rd_done), 1);
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_m_valid", 32'(mvalid_cycles - v0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
